// File: rtl/wb_pwm_sync_pkg.sv
// Shared constants for the Wishbone multi-channel PWM: register word addresses,
// CTRL field positions and the counter snapshot offset in the PERIOD readback.
package wb_pwm_sync_pkg;

  localparam int unsigned ADDR_CTRL      = 0;
  localparam int unsigned ADDR_PERIOD    = 1;
  localparam int unsigned ADDR_DUTY_BASE = 2;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_PRESC_LSB = 16;

  localparam int unsigned PERIOD_CNT_LSB = 16;

endpackage

// File: rtl/wb_pwm_sync_channel.sv
// One PWM channel: shadow duty register, boundary-synchronous active copy
// and the registered duty comparator.
module wb_pwm_sync_channel
  import wb_pwm_sync_pkg::*;
#(
  parameter int RES_WIDTH = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 en,
  input  logic                 boundary,
  input  logic                 duty_we,
  input  logic [RES_WIDTH-1:0] duty_wdata,
  input  logic [RES_WIDTH-1:0] cnt,
  output logic [RES_WIDTH-1:0] duty_shadow,
  output logic                 pwm
);

  logic [RES_WIDTH-1:0] duty_active;

  // The active copy samples the shadow before this cycle's write lands, so a
  // write coinciding with a boundary waits for the following one.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      duty_shadow <= '0;
      duty_active <= '0;
      pwm         <= 1'b0;
    end else begin
      if (duty_we) duty_shadow <= duty_wdata;
      if (!en || boundary) duty_active <= duty_shadow;
      pwm <= en && (cnt < duty_active);
    end
  end

endmodule

// File: rtl/wb_pwm_sync.sv
// Wishbone B4 pipelined multi-channel PWM with double-buffered period/duty.
// Define WB_PWM_SYNC_READBACK_EN to enable register readback; otherwise reads return 0.
module wb_pwm_sync
  import wb_pwm_sync_pkg::*;
#(
  parameter int RES_WIDTH   = 8,
  parameter int CHANNEL_NUM = 3,
  parameter int PRESC_WIDTH = 16,
  parameter int ADR_WIDTH   = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [ADR_WIDTH-1:0]   wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_stall_o,
  output logic                   wb_ack_o,
  output logic [CHANNEL_NUM-1:0] pwm_channel
);

  logic                                  req;
  logic                                  wr;
  logic                                  ctrl_we;
  logic                                  period_we;
  logic [CHANNEL_NUM-1:0]                duty_we;
  logic                                  en;
  logic [PRESC_WIDTH-1:0]                presc;
  logic [PRESC_WIDTH-1:0]                presc_cnt;
  logic [RES_WIDTH-1:0]                  period_shadow;
  logic [RES_WIDTH-1:0]                  period_active;
  logic [RES_WIDTH-1:0]                  cnt;
  logic                                  tick;
  logic                                  boundary;
  logic [CHANNEL_NUM-1:0][RES_WIDTH-1:0] duty_shadow;
  logic                                  unused_dat;

  assign req        = wb_cyc_i & wb_stb_i;
  assign wr         = req & wb_we_i;
  assign ctrl_we    = wr && (wb_adr_i == ADR_WIDTH'(ADDR_CTRL));
  assign period_we  = wr && (wb_adr_i == ADR_WIDTH'(ADDR_PERIOD));
  assign wb_stall_o = 1'b0;
  assign unused_dat = ^wb_dat_i;

  assign tick     = en && (presc_cnt == presc);
  assign boundary = tick && (cnt == period_active);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o      <= 1'b0;
      en            <= 1'b0;
      presc         <= '0;
      presc_cnt     <= '0;
      period_shadow <= '1;
      period_active <= '1;
      cnt           <= '0;
    end else begin
      wb_ack_o <= req;
      if (ctrl_we) begin
        en    <= wb_dat_i[CTRL_EN_BIT];
        presc <= wb_dat_i[CTRL_PRESC_LSB +: PRESC_WIDTH];
      end
      if (period_we) period_shadow <= wb_dat_i[RES_WIDTH-1:0];
      // Disabled: counters parked at 0 and the active period tracks the shadow.
      if (!en) begin
        presc_cnt     <= '0;
        cnt           <= '0;
        period_active <= period_shadow;
      end else begin
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        if (tick) cnt <= boundary ? '0 : cnt + 1'b1;
        if (boundary) period_active <= period_shadow;
      end
    end
  end

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_ch
    assign duty_we[i] = wr && (wb_adr_i == ADR_WIDTH'(ADDR_DUTY_BASE + i));

    wb_pwm_sync_channel #(
      .RES_WIDTH(RES_WIDTH)
    ) u_ch (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_ni  (wb_rst_ni),
      .en         (en),
      .boundary   (boundary),
      .duty_we    (duty_we[i]),
      .duty_wdata (wb_dat_i[RES_WIDTH-1:0]),
      .cnt        (cnt),
      .duty_shadow(duty_shadow[i]),
      .pwm        (pwm_channel[i])
    );
  end

`ifdef WB_PWM_SYNC_READBACK_EN
  logic [31:0] rd_data;
  logic [31:0] dat_q;

  always_comb begin
    rd_data = '0;
    if (wb_adr_i == ADR_WIDTH'(ADDR_CTRL)) begin
      rd_data[CTRL_EN_BIT]                   = en;
      rd_data[CTRL_PRESC_LSB +: PRESC_WIDTH] = presc;
    end else if (wb_adr_i == ADR_WIDTH'(ADDR_PERIOD)) begin
      rd_data[RES_WIDTH-1:0]                 = period_shadow;
      rd_data[PERIOD_CNT_LSB +: RES_WIDTH]   = cnt;
    end
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (wb_adr_i == ADR_WIDTH'(ADDR_DUTY_BASE + i)) rd_data[RES_WIDTH-1:0] = duty_shadow[i];
    end
  end

  // Data is only driven in the ack cycle of a read.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) dat_q <= '0;
    else            dat_q <= (req && !wb_we_i) ? rd_data : '0;
  end

  assign wb_dat_o = dat_q;
`else
  logic unused_rd;

  assign wb_dat_o  = '0;
  assign unused_rd = ^duty_shadow;
`endif

endmodule
